seven_seg_scan_driver: RTL and testbench



---
 rtl/seven_seg_scan_driver.sv | 129 ++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - time-multiplexed N-digit common-anode seven-segment scan driver
// Double-buffered hex frame, per-digit dp/blank, ghost-suppression gap, optional leading-zero blanking.
module seven_seg_scan_driver #(
   parameter int NUM_DIGITS   = 8,
   parameter int TICK_DIV     = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   digits,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic [NUM_DIGITS-1:0]     blank,
   input  logic                      lz_suppress,
   output logic [6:0]                segments,
   output logic                      dp,
   output logic [NUM_DIGITS-1:0]     anode,
   output logic                      frame_done
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = $clog2(NUM_DIGITS);
   localparam logic [PW-1:0] P_LAST  = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
   localparam logic [SW-1:0] S_LAST  = SW'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

   logic [PW-1:0]             p;
   logic [SW-1:0]             s;
   logic [4*NUM_DIGITS-1:0]   pend_dig;
   logic [NUM_DIGITS-1:0]     pend_dp;
   logic [NUM_DIGITS-1:0]     pend_blank;
   logic [4*NUM_DIGITS-1:0]   act_dig;
   logic [NUM_DIGITS-1:0]     act_dp;
   logic [NUM_DIGITS-1:0]     act_blank;

   logic                      tick;
   logic                      boundary;
   logic [NUM_DIGITS-1:0]     lead_zero;
   logic [NUM_DIGITS-1:0]     dark;
   logic [3:0]                cur_nib;
   logic                      lit;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] r;
      case (h)
         4'h0: r = 7'b0000001;
         4'h1: r = 7'b1001111;
         4'h2: r = 7'b0010010;
         4'h3: r = 7'b0000110;
         4'h4: r = 7'b1001100;
         4'h5: r = 7'b0100100;
         4'h6: r = 7'b0100000;
         4'h7: r = 7'b0001111;
         4'h8: r = 7'b0000000;
         4'h9: r = 7'b0000100;
         4'hA: r = 7'b0001000;
         4'hB: r = 7'b1100000;
         4'hC: r = 7'b0110001;
         4'hD: r = 7'b1000010;
         4'hE: r = 7'b0110000;
         default: r = 7'b0111000;
      endcase
      return r;
   endfunction

   assign tick     = enable && (p == P_LAST);
   assign boundary = tick && (s == S_LAST);

   // A digit is a leading zero when it and every more-significant digit are zero; digit 0 always shows.
   always_comb begin
      logic zero_run;
      lead_zero = '0;
      zero_run  = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_run     = zero_run && (act_dig[4*i +: 4] == 4'h0);
         lead_zero[i] = zero_run;
      end
   end

   assign dark    = act_blank | (lz_suppress ? lead_zero : '0);
   assign cur_nib = act_dig[{s, 2'b00} +: 4];
   assign lit     = enable && (p >= P_BLANK) && !dark[s];

   always_ff @(posedge clk) begin
      if (rst) begin
         p          <= '0;
         s          <= '0;
         pend_dig   <= '0;
         pend_dp    <= '0;
         pend_blank <= '0;
         act_dig    <= '0;
         act_dp     <= '0;
         act_blank  <= '0;
         anode      <= '1;
         segments   <= 7'b1111111;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= boundary;

         if (enable) begin
            p <= (p == P_LAST) ? '0 : p + PW'(1);
         end
         if (tick) begin
            s <= (s == S_LAST) ? '0 : s + SW'(1);
         end

         if (load) begin
            pend_dig   <= digits;
            pend_dp    <= dp_in;
            pend_blank <= blank;
         end

         // A load landing on the boundary bypasses pending so it is not held back a whole frame.
         if (boundary) begin
            act_dig   <= load ? digits : pend_dig;
            act_dp    <= load ? dp_in  : pend_dp;
            act_blank <= load ? blank  : pend_blank;
         end

         anode    <= lit ? ~(ONE_HOT0 << s) : '1;
         segments <= lit ? hex_to_seg(cur_nib) : 7'b1111111;
         dp       <= lit ? ~act_dp[s] : 1'b1;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - table-driven and sequence checks for seven_seg_scan_driver
// Uses NUM_DIGITS=4, TICK_DIV=8, BLANK_CYCLES=2.
module tb_seven_seg_scan_driver;

   localparam int N  = 4;
   localparam int TD = 8;
   localparam int BC = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        load;
   logic [15:0] digits;
   logic [3:0]  dp_in;
   logic [3:0]  blank;
   logic        lz;
   logic [6:0]  segments;
   logic        dp;
   logic [3:0]  anode;
   logic        frame_done;

   int pass_cnt  = 0;
   int total_cnt = 0;

   typedef struct packed {
      logic [15:0] dig;
      logic [3:0]  dpi;
      logic [3:0]  blk;
      logic        lz;
      logic [27:0] seg;    // {slot3, slot2, slot1, slot0} expected segment codes
      logic [3:0]  dark;
   } vec_t;

   vec_t vt [12];
   vec_t v2222;
   vec_t v5555;

   always #5 clk = ~clk;

   seven_seg_scan_driver #(
      .NUM_DIGITS  (N),
      .TICK_DIV    (TD),
      .BLANK_CYCLES(BC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .load       (load),
      .digits     (digits),
      .dp_in      (dp_in),
      .blank      (blank),
      .lz_suppress(lz),
      .segments   (segments),
      .dp         (dp),
      .anode      (anode),
      .frame_done (frame_done)
   );

   task automatic check(input string name, input logic [3:0] ea, input logic [6:0] es,
                        input logic edp, input logic efd);
      total_cnt++;
      if (anode === ea && segments === es && dp === edp && frame_done === efd) pass_cnt++;
      else $display("FAIL %s t=%0t: got anode=%b seg=%b dp=%b fd=%b, expected anode=%b seg=%b dp=%b fd=%b",
                    name, $time, anode, segments, dp, frame_done, ea, es, edp, efd);
   endtask

   task automatic expect_slot(input string name, input vec_t v, input int j, input int ph, input logic efd);
      logic       lt;
      logic [6:0] s7;
      logic [3:0] oh;
      lt = (ph >= BC) && !v.dark[j];
      s7 = 7'(v.seg >> (7 * j));
      oh = 4'b0001 << j;
      check(name, lt ? ~oh : 4'hF, lt ? s7 : 7'h7F, lt ? ~v.dpi[j] : 1'b1, efd);
   endtask

   task automatic wait_fd(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (frame_done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      total_cnt++;
      if (n < 200) pass_cnt++;
      else $display("FAIL %s: frame_done not seen within 200 cycles", name);
   endtask

   task automatic load_vec(input vec_t v);
      digits = v.dig;
      dp_in  = v.dpi;
      blank  = v.blk;
      lz     = v.lz;
      load   = 1'b1;
      @(negedge clk);
      load   = 1'b0;
   endtask

   // Called at the negedge where frame_done is high; checks the full following frame.
   task automatic check_frame(input string name, input vec_t v, input int load_k, input logic [15:0] ld);
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         if (k == load_k + 1) load = 1'b0;
         expect_slot(name, v, (k - 1) / 8, (k - 1) % 8, k == 32);
         if (k == load_k) begin
            digits = ld;
            dp_in  = 4'h0;
            blank  = 4'h0;
            load   = 1'b1;
         end
      end
   endtask

   initial begin
      vt[0]  = '{16'h1A3F, 4'b0000, 4'b0000, 1'b0, {7'h4F, 7'h08, 7'h06, 7'h38}, 4'b0000};
      vt[1]  = '{16'h0123, 4'b0101, 4'b0000, 1'b0, {7'h01, 7'h4F, 7'h12, 7'h06}, 4'b0000};
      vt[2]  = '{16'h4567, 4'b0010, 4'b0010, 1'b0, {7'h4C, 7'h24, 7'h20, 7'h0F}, 4'b0010};
      vt[3]  = '{16'h89AB, 4'b0000, 4'b0000, 1'b1, {7'h00, 7'h04, 7'h08, 7'h60}, 4'b0000};
      vt[4]  = '{16'hCDEF, 4'b1000, 4'b0000, 1'b0, {7'h31, 7'h42, 7'h30, 7'h38}, 4'b0000};
      vt[5]  = '{16'h0050, 4'b0000, 4'b0000, 1'b1, {7'h01, 7'h01, 7'h24, 7'h01}, 4'b1100};
      vt[6]  = '{16'h0000, 4'b0000, 4'b0000, 1'b1, {7'h01, 7'h01, 7'h01, 7'h01}, 4'b1110};
      vt[7]  = '{16'h0000, 4'b0000, 4'b0000, 1'b0, {7'h01, 7'h01, 7'h01, 7'h01}, 4'b0000};
      vt[8]  = '{16'h0305, 4'b0000, 4'b0000, 1'b1, {7'h01, 7'h06, 7'h01, 7'h24}, 4'b1000};
      vt[9]  = '{16'h1234, 4'b0100, 4'b0000, 1'b0, {7'h4F, 7'h12, 7'h06, 7'h4C}, 4'b0000};
      vt[10] = '{16'h1234, 4'b0100, 4'b0100, 1'b0, {7'h4F, 7'h12, 7'h06, 7'h4C}, 4'b0100};
      vt[11] = '{16'h7000, 4'b0000, 4'b0000, 1'b1, {7'h0F, 7'h01, 7'h01, 7'h01}, 4'b0000};
      v2222  = '{16'h2222, 4'b0000, 4'b0000, 1'b0, {7'h12, 7'h12, 7'h12, 7'h12}, 4'b0000};
      v5555  = '{16'h5555, 4'b0000, 4'b0000, 1'b0, {7'h24, 7'h24, 7'h24, 7'h24}, 4'b0000};

      // Reset held with a load pending: outputs dark, load discarded.
      rst = 1'b1; enable = 1'b1; load = 1'b1; digits = 16'hFFFF;
      dp_in = 4'hF; blank = 4'h0; lz = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset", 4'hF, 7'h7F, 1'b1, 1'b0);
      end
      rst = 1'b0; load = 1'b0;
      wait_fd("first_fd");
      check_frame("first_frame", vt[7], -1, 16'h0);

      for (int i = 0; i < 12; i++) begin
         load_vec(vt[i]);
         wait_fd($sformatf("vec%0d_fd", i));
         check_frame($sformatf("vec%0d", i), vt[i], -1, 16'h0);
      end

      // Mid-frame load stays pending; boundary-cycle load shows in the very next frame.
      load_vec(vt[0]);
      wait_fd("tear_fd");
      check_frame("tear_mid", vt[0], 12, 16'h2222);
      check_frame("tear_after", v2222, 31, 16'h5555);
      check_frame("boundary_load", v5555, -1, 16'h0);

      // Enable drop after slot 1 phase 5 output, 20 dark cycles, then resume.
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         expect_slot("en_pre", v5555, (k - 1) / 8, (k - 1) % 8, 1'b0);
      end
      enable = 1'b0;
      for (int k = 15; k <= 34; k++) begin
         @(negedge clk);
         check("en_off", 4'hF, 7'h7F, 1'b1, 1'b0);
      end
      enable = 1'b1;
      for (int k = 35; k <= 52; k++) begin
         int kk;
         kk = k - 20;
         @(negedge clk);
         expect_slot("en_resume", v5555, (kk - 1) / 8, (kk - 1) % 8, kk == 32);
      end

      // Reset mid-slot discards a pending load.
      digits = 16'h9999; dp_in = 4'h0; blank = 4'h0; lz = 1'b0; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_reset", 4'hF, 7'h7F, 1'b1, 1'b0);
      rst = 1'b0;
      wait_fd("post_reset_fd");
      check_frame("post_reset", vt[7], -1, 16'h0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
